// File: rtl/controller_sequencer_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, ring states
// and the control-word layout used by the decoder.
package controller_sequencer_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot ring states, bit 0 = T1.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    // Control word, MSB first in the same order as the datapath strobes.
    typedef struct packed {
        logic c_p;
        logic e_p;
        logic l_m;
        logic c_e;
        logic l_i;
        logic e_i;
        logic l_a;
        logic e_a;
        logic s_u;
        logic e_u;
        logic l_b;
        logic l_o;
    } ctrl_t;

    function automatic logic is_nop(input logic [3:0] op);
        return !(op == OP_LDA || op == OP_ADD || op == OP_SUB ||
                 op == OP_OUT || op == OP_HLT);
    endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// Six-state one-hot ring counter with synchronous clear to T1, a hold input
// used while halted and a load-T1 input used to cut instructions short.
module ring_counter
    import controller_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    input  logic       load_t1,
    output logic [5:0] t
);

    ring_t state;
    ring_t state_next;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= T1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = T1;
        if (hold) begin
            state_next = state;
        end else if (load_t1) begin
            state_next = T1;
        end else begin
            unique case (state)
                T1:      state_next = T2;
                T2:      state_next = T3;
                T3:      state_next = T4;
                T4:      state_next = T5;
                T5:      state_next = T6;
                T6:      state_next = T1;
                default: state_next = T1;
            endcase
        end
    end

    assign t = state;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter plus flat instruction decoder that
// produces the datapath control word and the latched HLT for the clock gate.
module controller_sequencer
    import controller_sequencer_pkg::*;
#(
    parameter bit EARLY_FETCH = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] opcode,
    output logic       C_P,
    output logic       E_P,
    output logic       L_M,
    output logic       C_E,
    output logic       L_I,
    output logic       E_I,
    output logic       L_A,
    output logic       E_A,
    output logic       S_U,
    output logic       E_U,
    output logic       L_B,
    output logic       L_O,
    output logic       HLT,
    output logic [5:0] T
);

    logic [5:0] t;
    logic       hlt_latch;
    logic       halt_now;
    logic       load_t1;
    ring_t      t_eff;
    ctrl_t      cw;

    assign halt_now = (t == T4) && (opcode == OP_HLT);

    assign load_t1 = EARLY_FETCH &&
                     (((t == T4) && (opcode == OP_OUT || is_nop(opcode))) ||
                      ((t == T5) && (opcode == OP_LDA)));

    ring_counter u_ring (
        .clk     (CLK),
        .clr     (CLR),
        .hold    (halt_now || hlt_latch),
        .load_t1 (load_t1),
        .t       (t)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            hlt_latch <= 1'b0;
        end else if (halt_now) begin
            hlt_latch <= 1'b1;
        end
    end

    // While CLR is high the outputs already show the T1 decode, so no
    // mid-instruction strobe escapes during the reset cycle.
    always_comb begin
        t_eff = CLR ? T1 : ring_t'(t);
        cw    = '0;
        unique case (t_eff)
            T1: begin
                cw.e_p = 1'b1;
                cw.l_m = 1'b1;
            end
            T2: cw.c_p = 1'b1;
            T3: begin
                cw.c_e = 1'b1;
                cw.l_i = 1'b1;
            end
            T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.e_i = 1'b1;
                    cw.l_m = 1'b1;
                end else if (opcode == OP_OUT) begin
                    cw.e_a = 1'b1;
                    cw.l_o = 1'b1;
                end
            end
            T5: begin
                if (opcode == OP_LDA) begin
                    cw.c_e = 1'b1;
                    cw.l_a = 1'b1;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.c_e = 1'b1;
                    cw.l_b = 1'b1;
                    cw.s_u = (opcode == OP_SUB);
                end
            end
            T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.e_u = 1'b1;
                    cw.l_a = 1'b1;
                    cw.s_u = (opcode == OP_SUB);
                end
            end
            default: cw = '0;
        endcase
        if (hlt_latch && !CLR) begin
            cw = '0;
        end
    end

    assign {C_P, E_P, L_M, C_E, L_I, E_I, L_A, E_A, S_U, E_U, L_B, L_O} = cw;
    assign HLT = !CLR && (halt_now || hlt_latch);
    assign T   = t;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed table-driven bench for controller_sequencer, with one instance per
// EARLY_FETCH setting and a random-opcode run checking the bus-driver rule.
module tb_controller_sequencer;

    localparam logic [11:0] M_CP = 12'h800;
    localparam logic [11:0] M_EP = 12'h400;
    localparam logic [11:0] M_LM = 12'h200;
    localparam logic [11:0] M_CE = 12'h100;
    localparam logic [11:0] M_LI = 12'h080;
    localparam logic [11:0] M_EI = 12'h040;
    localparam logic [11:0] M_LA = 12'h020;
    localparam logic [11:0] M_EA = 12'h010;
    localparam logic [11:0] M_SU = 12'h008;
    localparam logic [11:0] M_EU = 12'h004;
    localparam logic [11:0] M_LB = 12'h002;
    localparam logic [11:0] M_LO = 12'h001;
    localparam logic [11:0] M_BUS = M_EP | M_CE | M_EI | M_EA | M_EU;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    typedef struct {
        logic        sel;
        logic        clr;
        logic [3:0]  op;
        logic [5:0]  t;
        logic [11:0] cw;
        logic        hlt;
    } vec_t;

    logic        clk;
    logic        clr0;
    logic        clr1;
    logic [3:0]  op0;
    logic [3:0]  op1;
    wire  [11:0] cw0;
    wire  [11:0] cw1;
    wire         hlt0;
    wire         hlt1;
    wire  [5:0]  t0;
    wire  [5:0]  t1;

    int   checks;
    int   passes;
    vec_t vecs[$];

    controller_sequencer #(.EARLY_FETCH(1'b0)) dut (
        .CLK(clk), .CLR(clr0), .opcode(op0),
        .C_P(cw0[11]), .E_P(cw0[10]), .L_M(cw0[9]), .C_E(cw0[8]),
        .L_I(cw0[7]), .E_I(cw0[6]), .L_A(cw0[5]), .E_A(cw0[4]),
        .S_U(cw0[3]), .E_U(cw0[2]), .L_B(cw0[1]), .L_O(cw0[0]),
        .HLT(hlt0), .T(t0)
    );

    controller_sequencer #(.EARLY_FETCH(1'b1)) dut_ef (
        .CLK(clk), .CLR(clr1), .opcode(op1),
        .C_P(cw1[11]), .E_P(cw1[10]), .L_M(cw1[9]), .C_E(cw1[8]),
        .L_I(cw1[7]), .E_I(cw1[6]), .L_A(cw1[5]), .E_A(cw1[4]),
        .S_U(cw1[3]), .E_U(cw1[2]), .L_B(cw1[1]), .L_O(cw1[0]),
        .HLT(hlt1), .T(t1)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic add(input logic sel, input logic clr, input logic [3:0] op,
                       input logic [5:0] t, input logic [11:0] cw, input logic hlt);
        vec_t v;
        v.sel = sel; v.clr = clr; v.op = op; v.t = t; v.cw = cw; v.hlt = hlt;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic sel, input logic [3:0] op);
        add(sel, 1'b0, op, S1, M_EP | M_LM, 1'b0);
        add(sel, 1'b0, op, S2, M_CP,        1'b0);
        add(sel, 1'b0, op, S3, M_CE | M_LI, 1'b0);
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [5:0]  t_act;
        logic [11:0] cw_act;
        logic        hlt_act;
        t_act   = v.sel ? t1   : t0;
        cw_act  = v.sel ? cw1  : cw0;
        hlt_act = v.sel ? hlt1 : hlt0;
        checks++;
        if (t_act === v.t && cw_act === v.cw && hlt_act === v.hlt) begin
            passes++;
        end else begin
            $display("FAIL vec%0d dut%0d: got T=%b cw=%h hlt=%b, want T=%b cw=%h hlt=%b",
                     idx, v.sel, t_act, cw_act, hlt_act, v.t, v.cw, v.hlt);
        end
    endtask

    task automatic check_bus(input string name, input logic [11:0] cw);
        checks++;
        if ($onehot0(cw & M_BUS)) begin
            passes++;
        end else begin
            $display("FAIL %s: bus drivers cw=%h, want at most one of mask %h",
                     name, cw, M_BUS);
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;

        // EARLY_FETCH=0: ADD, SUB, LDA (opcode garbage during fetch), OUT, NOP
        add_fetch(1'b0, 4'h1);
        add(1'b0, 1'b0, 4'h1, S4, M_EI | M_LM, 1'b0);
        add(1'b0, 1'b0, 4'h1, S5, M_CE | M_LB, 1'b0);
        add(1'b0, 1'b0, 4'h1, S6, M_EU | M_LA, 1'b0);
        add_fetch(1'b0, 4'h2);
        add(1'b0, 1'b0, 4'h2, S4, M_EI | M_LM, 1'b0);
        add(1'b0, 1'b0, 4'h2, S5, M_CE | M_LB | M_SU, 1'b0);
        add(1'b0, 1'b0, 4'h2, S6, M_EU | M_LA | M_SU, 1'b0);
        add_fetch(1'b0, 4'hF);
        add(1'b0, 1'b0, 4'h0, S4, M_EI | M_LM, 1'b0);
        add(1'b0, 1'b0, 4'h0, S5, M_CE | M_LA, 1'b0);
        add(1'b0, 1'b0, 4'h0, S6, 12'h000,     1'b0);
        add_fetch(1'b0, 4'hE);
        add(1'b0, 1'b0, 4'hE, S4, M_EA | M_LO, 1'b0);
        add(1'b0, 1'b0, 4'hE, S5, 12'h000,     1'b0);
        add(1'b0, 1'b0, 4'hE, S6, 12'h000,     1'b0);
        add_fetch(1'b0, 4'h5);
        add(1'b0, 1'b0, 4'h5, S4, 12'h000,     1'b0);
        add(1'b0, 1'b0, 4'h5, S5, 12'h000,     1'b0);
        add(1'b0, 1'b0, 4'h5, S6, 12'h000,     1'b0);
        // LDA interrupted by CLR in T5: no L_A, next cycle is T1
        add_fetch(1'b0, 4'h0);
        add(1'b0, 1'b0, 4'h0, S4, M_EI | M_LM, 1'b0);
        add(1'b0, 1'b1, 4'h0, S5, M_EP | M_LM, 1'b0);
        add(1'b0, 1'b0, 4'h0, S1, M_EP | M_LM, 1'b0);
        add(1'b0, 1'b0, 4'h0, S2, M_CP,        1'b0);
        add(1'b0, 1'b0, 4'hF, S3, M_CE | M_LI, 1'b0);
        // HLT: freeze in T4, outputs masked even if opcode changes
        add(1'b0, 1'b0, 4'hF, S4, 12'h000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            add(1'b0, 1'b0, (i < 5) ? 4'hF : 4'h1, S4, 12'h000, 1'b1);
        end
        add(1'b0, 1'b1, 4'h1, S4, M_EP | M_LM, 1'b0);
        add(1'b0, 1'b0, 4'h1, S1, M_EP | M_LM, 1'b0);
        add(1'b0, 1'b0, 4'h1, S2, M_CP,        1'b0);

        // EARLY_FETCH=1: OUT (4), NOP (4), LDA (5), ADD (6)
        add_fetch(1'b1, 4'hE);
        add(1'b1, 1'b0, 4'hE, S4, M_EA | M_LO, 1'b0);
        add_fetch(1'b1, 4'h5);
        add(1'b1, 1'b0, 4'h5, S4, 12'h000,     1'b0);
        add_fetch(1'b1, 4'h0);
        add(1'b1, 1'b0, 4'h0, S4, M_EI | M_LM, 1'b0);
        add(1'b1, 1'b0, 4'h0, S5, M_CE | M_LA, 1'b0);
        add_fetch(1'b1, 4'h1);
        add(1'b1, 1'b0, 4'h1, S4, M_EI | M_LM, 1'b0);
        add(1'b1, 1'b0, 4'h1, S5, M_CE | M_LB, 1'b0);
        add(1'b1, 1'b0, 4'h1, S6, M_EU | M_LA, 1'b0);
        add(1'b1, 1'b0, 4'h1, S1, M_EP | M_LM, 1'b0);

        // Both instances held in reset for two edges
        clr0 = 1'b1; clr1 = 1'b1; op0 = 4'h0; op1 = 4'h0;
        @(posedge clk);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].sel) begin
                clr0 = 1'b1;
                clr1 = vecs[i].clr;
                op1  = vecs[i].op;
            end else begin
                clr0 = vecs[i].clr;
                op0  = vecs[i].op;
            end
            #1;
            check_vec(i, vecs[i]);
        end

        // Random opcodes on both instances
        @(negedge clk);
        clr0 = 1'b1; clr1 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0; clr1 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            op0 = 4'($urandom_range(0, 14));
            op1 = 4'($urandom_range(0, 14));
            #1;
            check_bus("bus_dut0", cw0);
            check_bus("bus_dut1", cw1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
